// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   FETCH_ADDR_W / FETCH_DATA_W : widths of the queue entry fields
//   PC_STEP                     : byte increment between sequential fetches
//   DEFAULT_RESET_PC            : PC loaded on reset unless overridden
//   fetch_state_t               : RUN (fetching) / HALT (fetch suspended)
//   fetch_entry_t               : one queued instruction with its PC
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int FETCH_ADDR_W = 64;
    localparam int FETCH_DATA_W = 32;

    localparam int PC_STEP = 4;
    localparam logic [FETCH_ADDR_W-1:0] DEFAULT_RESET_PC = '0;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Small synchronous FIFO of fetch_entry_t between fetch and decode.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (empties the queue)
//   push        : write push_entry at the tail this cycle
//   push_entry  : entry to write
//   pop         : retire the head entry this cycle
//   flush       : empty the queue; overrides push and pop
//   head_entry  : entry at the head (registered storage, undefined when empty)
//   count       : current occupancy, 0..DEPTH
// The caller only pushes when not full or when popping in the same cycle,
// and only pops when not empty. DEPTH must be a power of two >= 2 so that
// the pointers wrap naturally at DEPTH.
// ---------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head_entry,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            // Simultaneous push and pop leaves occupancy unchanged, even when full.
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: the head is qualified by count everywhere it is used.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    assign head_entry = mem[rd_ptr_reg];
    assign count      = count_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Fetch stage in front of the instruction memory. Owns the PC, captures each
// fetched instruction with its PC into fetch_queue and hands entries to decode
// over a valid/ready handshake. A taken branch flushes the queue and redirects
// the PC; a misaligned redirect target is reported with a one-cycle pulse.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   Fetch_Enable      : 1 = fetching allowed, 0 = PC holds and nothing enqueues
//   Inst_Address      : byte address to instruction memory (the PC register)
//   Instruction       : memory data for Inst_Address, same cycle
//   Branch_Taken      : redirect request (highest priority)
//   Branch_Target     : redirect byte address (low two bits cleared on load)
//   Inst_Out, Inst_PC : queue head instruction and PC, 0 when queue empty
//   Inst_Valid        : head valid, suppressed during a redirect
//   Inst_Ready        : decode accepts the head
//   Queue_Count       : queue occupancy
//   Fetch_Misaligned  : one-cycle pulse after a redirect with target[1:0]!=0
// ---------------------------------------------------------------------------
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC[ADDR_W-1:0]
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       Fetch_Enable,
    output logic [ADDR_W-1:0]          Inst_Address,
    input  logic [DATA_W-1:0]          Instruction,
    input  logic                       Branch_Taken,
    input  logic [ADDR_W-1:0]          Branch_Target,
    output logic [DATA_W-1:0]          Inst_Out,
    output logic [ADDR_W-1:0]          Inst_PC,
    output logic                       Inst_Valid,
    input  logic                       Inst_Ready,
    output logic [$clog2(DEPTH):0]     Queue_Count,
    output logic                       Fetch_Misaligned
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]  pc_reg;
    logic               misaligned_reg;
    fetch_state_t       state_reg;
    fetch_state_t       state_next;
    logic               fetch_go;

    logic               queue_nonempty;
    logic               queue_full;
    logic               deq;
    logic               enq;
    fetch_entry_t       push_entry;
    fetch_entry_t       head_entry;
    logic [CW-1:0]      queue_count;

    // ---------------- run/halt FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Fetch_Enable is honoured in the same cycle it is sampled; the state
    // register records which mode the stage is in for the next cycle.
    always_comb begin
        state_next = state_reg;
        fetch_go   = 1'b0;
        case (state_reg)
            RUN: begin
                fetch_go = Fetch_Enable;
                if (!Fetch_Enable) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                fetch_go = Fetch_Enable;
                if (Fetch_Enable) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
                fetch_go   = 1'b0;
            end
        endcase
    end

    // ---------------- handshake / enqueue decisions ----------------
    assign queue_nonempty = (queue_count != '0);
    assign queue_full     = (queue_count == CW'(DEPTH));
    assign Inst_Valid     = queue_nonempty && !Branch_Taken;
    assign deq            = Inst_Valid && Inst_Ready;
    // A full queue still accepts a new entry when the head leaves this cycle.
    assign enq            = fetch_go && !Branch_Taken && (!queue_full || deq);

    assign push_entry.pc    = FETCH_ADDR_W'(pc_reg);
    assign push_entry.instr = FETCH_DATA_W'(Instruction);

    fetch_queue #(
        .DEPTH      (DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (enq),
        .push_entry (push_entry),
        .pop        (deq),
        .flush      (Branch_Taken),
        .head_entry (head_entry),
        .count      (queue_count)
    );

    // ---------------- PC and misaligned pulse ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg         <= RESET_PC;
            misaligned_reg <= 1'b0;
        end else begin
            misaligned_reg <= Branch_Taken && (|Branch_Target[1:0]);
            if (Branch_Taken) begin
                pc_reg <= {Branch_Target[ADDR_W-1:2], 2'b00};
            end else if (enq) begin
                pc_reg <= pc_reg + ADDR_W'(PC_STEP);  // wraps silently
            end
        end
    end

    // ---------------- outputs ----------------
    assign Inst_Address     = pc_reg;
    assign Inst_Out         = queue_nonempty ? head_entry.instr[DATA_W-1:0] : '0;
    assign Inst_PC          = queue_nonempty ? head_entry.pc[ADDR_W-1:0] : '0;
    assign Queue_Count      = queue_count;
    assign Fetch_Misaligned = misaligned_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed stimulus for instruction_fetch_unit with a queue-based reference
// model checked on every falling edge, plus literal expectations per scenario.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    localparam int AW    = 64;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam logic [31:0] MEM_XOR = 32'hA5A5_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          fe;
    logic          bt;
    logic          rdy;
    logic [AW-1:0] tgt;
    logic [AW-1:0] inst_address;
    logic [DW-1:0] instruction;
    logic [DW-1:0] inst_out;
    logic [AW-1:0] inst_pc;
    logic          inst_valid;
    logic [1:0]    queue_count;
    logic          fetch_misaligned;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // Memory model: combinational, word = address[31:0] ^ A5A5_0000.
    assign instruction = inst_address[31:0] ^ MEM_XOR;

    instruction_fetch_unit #(
        .ADDR_W           (AW),
        .DATA_W           (DW),
        .DEPTH            (DEPTH),
        .RESET_PC         (64'h0)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .Fetch_Enable     (fe),
        .Inst_Address     (inst_address),
        .Instruction      (instruction),
        .Branch_Taken     (bt),
        .Branch_Target    (tgt),
        .Inst_Out         (inst_out),
        .Inst_PC          (inst_pc),
        .Inst_Valid       (inst_valid),
        .Inst_Ready       (rdy),
        .Queue_Count      (queue_count),
        .Fetch_Misaligned (fetch_misaligned)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_pc  = 64'h0;
    logic        m_mis = 1'b0;

    task automatic model_step();
        bit   m_deq;
        bit   m_enq;
        ent_t e;
        if (reset) begin
            mq.delete();
            m_pc  = 64'h0;
            m_mis = 1'b0;
        end else if (bt) begin
            mq.delete();
            m_pc  = tgt & ~64'h3;
            m_mis = (tgt % 4) != 0;
        end else begin
            m_mis = 1'b0;
            m_deq = (mq.size() != 0) && rdy;
            m_enq = fe && ((mq.size() < DEPTH) || m_deq);
            if (m_deq) begin
                void'(mq.pop_front());
            end
            if (m_enq) begin
                e.pc    = m_pc;
                e.instr = m_pc[31:0] ^ MEM_XOR;
                mq.push_back(e);
                m_pc = m_pc + 64'd4;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    // Compare process: outputs are stable at the falling edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("cmp_addr",  inst_address, m_pc);
            check("cmp_count", 64'(queue_count), 64'(mq.size()));
            check("cmp_valid", 64'(inst_valid), 64'((mq.size() != 0) && !bt));
            check("cmp_mis",   64'(fetch_misaligned), 64'(m_mis));
            if (mq.size() != 0) begin
                check("cmp_out", 64'(inst_out), 64'(mq[0].instr));
                check("cmp_pc",  inst_pc, mq[0].pc);
            end else begin
                check("cmp_out_empty", 64'(inst_out), 64'h0);
                check("cmp_pc_empty",  inst_pc, 64'h0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        $display("cycle t=%0t addr=%h cnt=%0d valid=%0d head_pc=%h head=%h mis=%0d",
                 $time, inst_address, queue_count, inst_valid, inst_pc, inst_out, fetch_misaligned);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [63:0] frozen_addr;

    initial begin
        reset = 1'b1; fe = 1'b0; bt = 1'b0; rdy = 1'b0; tgt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_addr",  inst_address, 64'h0);
        check("rst_count", 64'(queue_count), 64'h0);
        check("rst_valid", 64'(inst_valid), 64'h0);
        check("rst_out",   64'(inst_out), 64'h0);
        check("rst_pc",    inst_pc, 64'h0);
        check("rst_mis",   64'(fetch_misaligned), 64'h0);
        reset = 1'b0;

        // 1: streaming fetch
        fe = 1'b1; rdy = 1'b1;
        check("t1_addr0", inst_address, 64'h0);
        step();
        check("t1_addr4", inst_address, 64'h4);
        check("t1_pc0",   inst_pc, 64'h0);
        check("t1_out0",  64'(inst_out), 64'hA5A5_0000);
        check("t1_valid", 64'(inst_valid), 64'h1);
        step();
        check("t1_addr8", inst_address, 64'h8);
        check("t1_pc4",   inst_pc, 64'h4);
        step();
        check("t1_addr12", inst_address, 64'hC);
        check("t1_pc8",    inst_pc, 64'h8);

        // 2: back-pressure from PC=0
        reset = 1'b1;
        step();
        reset = 1'b0; fe = 1'b1; rdy = 1'b0;
        step();
        check("t2_cnt1", 64'(queue_count), 64'h1);
        step();
        check("t2_cnt2", 64'(queue_count), 64'h2);
        check("t2_addr8a", inst_address, 64'h8);
        step();
        check("t2_cnt2b", 64'(queue_count), 64'h2);
        check("t2_addr8b", inst_address, 64'h8);
        check("t2_hold_pc0", inst_pc, 64'h0);
        step();
        check("t2_cnt2c", 64'(queue_count), 64'h2);
        step();
        check("t2_addr8c", inst_address, 64'h8);
        rdy = 1'b1;
        #1;
        check("t2_head0", inst_pc, 64'h0);
        step();
        check("t2_head4", inst_pc, 64'h4);
        step();
        check("t2_head8", inst_pc, 64'h8);
        check("t2_addr16", inst_address, 64'h10);

        // 3: redirect with two entries queued
        rdy = 1'b0;
        step();
        check("t3_cnt2", 64'(queue_count), 64'h2);
        bt = 1'b1; tgt = 64'h100;
        #1;
        check("t3_valid_suppressed", 64'(inst_valid), 64'h0);
        step();
        bt = 1'b0;
        check("t3_flushed", 64'(queue_count), 64'h0);
        check("t3_addr100", inst_address, 64'h100);
        rdy = 1'b1;
        step();
        check("t3_pc100",  inst_pc, 64'h100);
        check("t3_out100", 64'(inst_out), 64'hA5A5_0100);

        // 4: misaligned redirect
        bt = 1'b1; tgt = 64'h106;
        step();
        bt = 1'b0;
        check("t4_mis1",    64'(fetch_misaligned), 64'h1);
        check("t4_addr104", inst_address, 64'h104);
        step();
        check("t4_mis0",    64'(fetch_misaligned), 64'h0);

        // 5: full queue with push+pop, then drain while halted
        rdy = 1'b0;
        step();
        step();
        check("t5_full", 64'(queue_count), 64'h2);
        check("t5_addr10c", inst_address, 64'h10C);
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_cnt_steady", 64'(queue_count), 64'h2);
        end
        check("t5_addr118", inst_address, 64'h118);
        fe = 1'b0;
        frozen_addr = inst_address;
        step();
        check("t5_drain1", 64'(queue_count), 64'h1);
        step();
        check("t5_drain0", 64'(queue_count), 64'h0);
        check("t5_frozen", inst_address, frozen_addr);
        step();
        check("t5_empty_valid", 64'(inst_valid), 64'h0);

        // 6: PC wrap, then asynchronous reset mid-cycle
        fe = 1'b1; bt = 1'b1; tgt = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        bt = 1'b0;
        check("t6_addr_top", inst_address, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check("t6_wrap0",   inst_address, 64'h0);
        check("t6_pc_top",  inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("t6_out_top", 64'(inst_out), 64'h5A5A_FFFC);
        step();
        check("t6_addr4", inst_address, 64'h4);
        #2;
        reset = 1'b1;
        #1;
        check("t6_arst_addr",  inst_address, 64'h0);
        check("t6_arst_count", 64'(queue_count), 64'h0);
        check("t6_arst_valid", 64'(inst_valid), 64'h0);
        check("t6_arst_out",   64'(inst_out), 64'h0);
        check("t6_arst_pc",    inst_pc, 64'h0);
        check("t6_arst_mis",   64'(fetch_misaligned), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        check("t6_restart_addr", inst_address, 64'h4);
        check("t6_restart_pc",   inst_pc, 64'h0);
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
